// File: rtl/seq_detector_n.sv
// Parametrised Moore serial-pattern detector with saturating hit counter.
// Optional SEQ_DET_MASK_EN adds a MASK parameter for don't-care bit positions.
module seq_detector_n #(
  parameter int unsigned      W       = 4,
  parameter logic [W-1:0]     PATTERN = 4'b1011,
  parameter int unsigned      OVERLAP = 1,
  parameter int unsigned      CNT_W   = 8
`ifdef SEQ_DET_MASK_EN
  ,
  parameter logic [W-1:0]     MASK    = '1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  output logic             F,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             full
);

`ifndef SEQ_DET_MASK_EN
  localparam logic [W-1:0] MASK = '1;
`endif

  localparam int unsigned   FW     = $clog2(W + 1);
  localparam logic [FW-1:0] FILL_W = FW'(W);

  logic [W-1:0]     hist, hist_n, nh;
  logic [FW-1:0]    fill, fill_n, nf;
  logic [CNT_W-1:0] cnt_n;
  logic             f_n, match;

  // Candidate history/fill and pattern compare for an enabled edge
  always_comb begin
    nh    = {hist[W-2:0], x};
    nf    = (fill == FILL_W) ? fill : fill + 1'b1;
    match = (nf == FILL_W) && (((nh ^ PATTERN) & MASK) == '0);
  end

  // Next state: clr beats en; idle edges hold state and drop F
  always_comb begin
    hist_n = hist;
    fill_n = fill;
    cnt_n  = hit_cnt;
    f_n    = 1'b0;
    if (clr) begin
      hist_n = '0;
      fill_n = '0;
      cnt_n  = '0;
    end else if (en) begin
      hist_n = nh;
      f_n    = match;
      fill_n = (match && OVERLAP == 0) ? '0 : nf;
      if (match && hit_cnt != '1)
        cnt_n = hit_cnt + 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= '0;
      fill    <= '0;
      F       <= 1'b0;
      hit_cnt <= '0;
    end else begin
      hist    <= hist_n;
      fill    <= fill_n;
      F       <= f_n;
      hit_cnt <= cnt_n;
    end
  end

  assign full = (fill == FILL_W);

endmodule
